hello_scroller: RTL and testbench



---
 rtl/hello_pkg.sv | 21 ++
 rtl/hex_char_decoder.sv | 21 ++
 rtl/hello_scroller.sv | 66 ++++++
 tb/tb_hello_scroller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared character codes, segment patterns and the fixed scroll message.
package hello_pkg;

   typedef logic [2:0] char_t;

   localparam char_t CH_H     = 3'b000;
   localparam char_t CH_E     = 3'b001;
   localparam char_t CH_L     = 3'b010;
   localparam char_t CH_O     = 3'b011;
   localparam char_t CH_BLANK = 3'b100;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_H     = 7'b000_1001;
   localparam logic [6:0] SEG_E     = 7'b000_0110;
   localparam logic [6:0] SEG_L     = 7'b100_0111;
   localparam logic [6:0] SEG_O     = 7'b100_0000;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;

   localparam char_t MSG [0:7] = '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK, CH_BLANK, CH_BLANK};

endpackage

// File: rtl/hex_char_decoder.sv
// Combinational 3-bit character code to active-low 7-segment pattern.
module hex_char_decoder
   import hello_pkg::*;
(
   input  logic [2:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!code_i[2]) begin
         unique case (code_i[1:0])
            2'b00:   seg_o = SEG_H;
            2'b01:   seg_o = SEG_E;
            2'b10:   seg_o = SEG_L;
            default: seg_o = SEG_O;
         endcase
      end
   end

endmodule

// File: rtl/hello_scroller.sv
// Scrolls "HELLO" across HEX7..HEX0; SW[0] runs/pauses, SW[1] picks direction.
module hello_scroller
   import hello_pkg::*;
#(
   parameter int unsigned TICK_COUNT = 25_000_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [1:0] SW,
   output logic [6:0] HEX7,
   output logic [6:0] HEX6,
   output logic [6:0] HEX5,
   output logic [6:0] HEX4,
   output logic [6:0] HEX3,
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0
);

   localparam int unsigned CNT_W = $clog2(TICK_COUNT);

   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       ptr_q;
   logic             tick;
   logic [6:0]       seg   [8];
   logic [6:0]       hex_q [8];

   assign tick = SW[0] && (cnt_q == CNT_W'(TICK_COUNT - 1));

   // seg[k] is the pattern for HEX(7-k), i.e. msg[(ptr+k) mod 8]
   for (genvar k = 0; k < 8; k++) begin : g_dig
      logic [2:0] idx;
      assign idx = ptr_q + 3'(k);
      hex_char_decoder u_dec (
         .code_i (MSG[idx]),
         .seg_o  (seg[k])
      );
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt_q <= '0;
         ptr_q <= '0;
         hex_q <= '{default: SEG_BLANK};
      end else begin
         // Pausing freezes the count rather than clearing it.
         if (SW[0]) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
         end
         if (tick) begin
            ptr_q <= SW[1] ? ptr_q - 3'd1 : ptr_q + 3'd1;
         end
         hex_q <= seg;
      end
   end

   assign HEX7 = hex_q[0];
   assign HEX6 = hex_q[1];
   assign HEX5 = hex_q[2];
   assign HEX4 = hex_q[3];
   assign HEX3 = hex_q[4];
   assign HEX2 = hex_q[5];
   assign HEX1 = hex_q[6];
   assign HEX0 = hex_q[7];

endmodule

// File: tb/tb_hello_scroller.sv
// Directed bench for hello_scroller with a 4-cycle scroll step.
module tb_hello_scroller;

   logic       clk;
   logic       reset;
   logic [1:0] SW;
   logic [6:0] HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] H = 7'h09;
   localparam logic [6:0] E = 7'h06;
   localparam logic [6:0] L = 7'h47;
   localparam logic [6:0] O = 7'h40;
   localparam logic [6:0] B = 7'h7F;

   localparam logic [55:0] ALL_BLANK = {8{B}};
   localparam logic [55:0] HOME      = {H, E, L, L, O, B, B, B};

   hello_scroller #(
      .TICK_COUNT (4)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .SW       (SW),
      .HEX7     (HEX7),
      .HEX6     (HEX6),
      .HEX5     (HEX5),
      .HEX4     (HEX4),
      .HEX3     (HEX3),
      .HEX2     (HEX2),
      .HEX1     (HEX1),
      .HEX0     (HEX0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {HEX7..HEX0} for a given pointer; HEX(7-k) shows msg[(p+k) mod 8].
   function automatic logic [55:0] frame(input int p);
      logic [6:0] tab [8];
      logic [55:0] f;
      tab = '{H, E, L, L, O, B, B, B};
      f = '0;
      for (int k = 0; k < 8; k++) begin
         f[55 - 7*k -: 7] = tab[(p + k) % 8];
      end
      return f;
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [55:0] exp);
      logic [55:0] obs;
      obs = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Leaves the bench at a falling edge with reset just released; next rising edge is cycle 1.
   task automatic do_reset(input logic [1:0] sw);
      reset = 1'b1;
      step(2);
      SW    = sw;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      SW    = 2'b00;
      step(1);
      check("reset_blank", ALL_BLANK);

      // 1: paused from release, home frame held
      do_reset(2'b00);
      step(1);
      check("pause_home_c1", HOME);
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("pause_hold", HOME);
      end

      // 2: scroll left, first change at cycle 5, full wrap after 8 ticks
      do_reset(2'b01);
      step(4);
      check("left_c4_home", HOME);
      step(1);
      check("left_c5", {E, L, L, O, B, B, B, H});
      step(4);
      check("left_c9", frame(2));
      step(23);
      check("left_c32", frame(7));
      step(1);
      check("left_c33_wrap", HOME);

      // 3: scroll right, 0 -> 7 wrap
      do_reset(2'b11);
      step(4);
      check("right_c4_home", HOME);
      step(1);
      check("right_c5", {B, H, E, L, L, O, B, B});
      step(4);
      check("right_c9", frame(6));

      // 4: pause at cnt=2 for 10 cycles, resume
      do_reset(2'b01);
      step(2);
      SW = 2'b00;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("midpause_frozen", HOME);
      end
      SW = 2'b01;
      step(1);
      check("resume_c1", HOME);
      step(1);
      check("resume_c2_tick", HOME);
      step(1);
      check("resume_c3_update", frame(1));

      // 5: direction flip mid-period
      do_reset(2'b01);
      step(6);
      check("flip_c6", frame(1));
      SW = 2'b11;
      step(2);
      check("flip_c8", frame(1));
      step(1);
      check("flip_c9_back", HOME);
      step(3);
      check("flip_c12", HOME);
      step(1);
      check("flip_c13", frame(7));

      // 6: reset with ptr=5, cnt=3, running
      do_reset(2'b01);
      step(23);
      check("pre_reset_ptr5", frame(5));
      reset = 1'b1;
      step(1);
      check("reset_midrun_blank", ALL_BLANK);
      reset = 1'b0;
      step(1);
      check("rerelease_c1_home", HOME);
      step(3);
      check("rerelease_c4_home", HOME);
      step(1);
      check("rerelease_c5", frame(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
